// File: rtl/tmr_universal_register_top.sv
// Triple-redundant 4-bit universal shift register (SISO/SIPO/PISO/PIPO).
// Each replica computes its next state from the voted value, so a corrupted copy is scrubbed on the next edge.

module tmr_register_replica #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic [WIDTH-1:0] voted,
  output logic [WIDTH-1:0] reg_data
);

  localparam logic [1:0] MODE_PISO = 2'b10;
  localparam logic [1:0] MODE_PIPO = 2'b11;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] reg_data_next;

  assign shifted = {voted[WIDTH-2:0], serial_in};

  // Continuous assignment so a released force snaps straight back to the
  // computed value instead of lingering until an input changes.
  assign reg_data_next = !rst                                 ? '0          :
                         !enable                              ? voted       :
                         (mode == MODE_PIPO)                  ? (load ? parallel_in : voted) :
                         ((mode == MODE_PISO) && load)        ? parallel_in :
                                                                shifted;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_data <= '0;
    end else begin
      reg_data <= reg_data_next;
    end
  end

endmodule

module tmr_universal_register_top #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r3;
  logic [WIDTH-1:0] voted;

  tmr_register_replica #(.WIDTH(WIDTH)) register_1 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .load        (load),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .voted       (voted),
    .reg_data    (r1)
  );

  tmr_register_replica #(.WIDTH(WIDTH)) register_2 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .load        (load),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .voted       (voted),
    .reg_data    (r2)
  );

  tmr_register_replica #(.WIDTH(WIDTH)) register_3 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .load        (load),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .voted       (voted),
    .reg_data    (r3)
  );

  // Bitwise 2-of-3 majority.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_vote
    assign voted[gi] = (r1[gi] & r2[gi]) | (r1[gi] & r3[gi]) | (r2[gi] & r3[gi]);
  end

  assign parallel_out = voted;
  assign serial_out   = voted[WIDTH-1];

endmodule

// File: tb/tb_tmr_universal_register_top.sv
// Self-checking bench for the TMR universal register: directed scenarios with
// single-replica fault injection plus a randomized run against a value-level model.

module tb_tmr_universal_register_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic       serial_in = 1'b0;
  logic [3:0] parallel_in = 4'h0;
  logic       serial_out;
  logic [3:0] parallel_out;

  int n_cmp = 0;
  int n_err = 0;
  int model = 0;  // expected register contents as an integer 0..15

  tmr_universal_register_top #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .load         (load),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out),
    .parallel_out (parallel_out)
  );

  always #5 clk = ~clk;

  // Register behaviour stated as arithmetic on the stored value.
  function automatic int model_next(int state);
    if (rst !== 1'b1) return 0;
    if (enable !== 1'b1) return state;
    if (mode == 2'b11) return load ? int'(parallel_in) : state;
    if (mode == 2'b10 && load) return int'(parallel_in);
    return (state * 2 + int'(serial_in)) % 16;
  endfunction

  task automatic tick;
    int nxt;
    nxt = model_next(model);
    @(posedge clk);
    #1;
    model = nxt;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b1; mode = 2'b10; load = 1'b1; parallel_in = 4'hF;
    tick();
    n_cmp++;
    if (parallel_out !== 4'h0 || serial_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset: parallel_out=%b serial_out=%b, required 0000/0", parallel_out, serial_out);
    end
  endtask

  task automatic test_siso;
    logic [3:0] seq;
    seq = 4'b1110;  // serial_in order 0,1,1,1 (bit 0 first)
    rst = 1'b1; enable = 1'b1; mode = 2'b00; load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serial_in = seq[i];
      tick();
      n_cmp++;
      if (parallel_out !== 4'(model) || serial_out !== model[3]) begin
        n_err++;
        $display("FAIL siso step %0d: parallel_out=%b serial_out=%b, required %b/%b",
                 i, parallel_out, serial_out, 4'(model), model[3]);
      end
    end
  endtask

  task automatic test_siso_fault;
    // Bring state to 0001, then hold and corrupt replica 3.
    rst = 1'b0; tick();
    rst = 1'b1; enable = 1'b1; mode = 2'b00; serial_in = 1'b1; tick();
    enable = 1'b0;
    force dut.register_3.reg_data = 4'b0111;
    #1;
    n_cmp++;
    if (parallel_out !== 4'b0001) begin
      n_err++;
      $display("FAIL siso_fault masked: parallel_out=%b, required 0001", parallel_out);
    end
    tick();
    release dut.register_3.reg_data;
    n_cmp++;
    if (parallel_out !== 4'b0001 || serial_out !== 1'b0) begin
      n_err++;
      $display("FAIL siso_fault hold: parallel_out=%b serial_out=%b, required 0001/0", parallel_out, serial_out);
    end
    tick();
    n_cmp++;
    if (dut.register_3.reg_data !== 4'b0001 || parallel_out !== 4'b0001) begin
      n_err++;
      $display("FAIL siso_fault scrub: register_3=%b parallel_out=%b, required 0001/0001",
               dut.register_3.reg_data, parallel_out);
    end
  endtask

  task automatic test_sipo_hold;
    rst = 1'b0; tick();
    rst = 1'b1; enable = 1'b1; mode = 2'b01; load = 1'b1;
    serial_in = 1'b1; tick();
    serial_in = 1'b0; tick();
    enable = 1'b0; serial_in = 1'b1;
    force dut.register_1.reg_data = 4'b0111;
    tick();
    release dut.register_1.reg_data;
    n_cmp++;
    if (parallel_out !== 4'b0010) begin
      n_err++;
      $display("FAIL sipo_hold first: parallel_out=%b, required 0010", parallel_out);
    end
    tick();
    n_cmp++;
    if (parallel_out !== 4'b0010 || dut.register_1.reg_data !== 4'b0010) begin
      n_err++;
      $display("FAIL sipo_hold second: parallel_out=%b register_1=%b, required 0010/0010",
               parallel_out, dut.register_1.reg_data);
    end
    enable = 1'b1;
    serial_in = 1'b0; tick();
    serial_in = 1'b1; tick();
    n_cmp++;
    if (parallel_out !== 4'b1001 || serial_out !== 1'b1 || model != 9) begin
      n_err++;
      $display("FAIL sipo_final: parallel_out=%b serial_out=%b, required 1001/1", parallel_out, serial_out);
    end
  endtask

  task automatic test_piso;
    rst = 1'b1; enable = 1'b1; mode = 2'b10; load = 1'b1; parallel_in = 4'b0110;
    tick();
    n_cmp++;
    if (parallel_out !== 4'b0110) begin
      n_err++;
      $display("FAIL piso load: parallel_out=%b, required 0110", parallel_out);
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      if (i == 1) force dut.register_2.reg_data = 4'b1111;
      tick();
      if (i == 1) release dut.register_2.reg_data;
      n_cmp++;
      if (parallel_out !== 4'(model) || serial_out !== model[3]) begin
        n_err++;
        $display("FAIL piso shift %0d: parallel_out=%b serial_out=%b, required %b/%b",
                 i, parallel_out, serial_out, 4'(model), model[3]);
      end
    end
  endtask

  task automatic test_pipo_fault;
    rst = 1'b1; enable = 1'b1; mode = 2'b11; load = 1'b1; parallel_in = 4'b1110;
    tick();
    load = 1'b0; parallel_in = 4'b0001;
    force dut.register_3.reg_data_next = 4'b1111;
    tick();
    release dut.register_3.reg_data_next;
    n_cmp++;
    if (parallel_out !== 4'b1110 || serial_out !== 1'b1) begin
      n_err++;
      $display("FAIL pipo masked: parallel_out=%b serial_out=%b, required 1110/1", parallel_out, serial_out);
    end
    tick();
    n_cmp++;
    if (dut.register_3.reg_data !== 4'b1110 || parallel_out !== 4'b1110) begin
      n_err++;
      $display("FAIL pipo scrub: register_3=%b parallel_out=%b, required 1110/1110",
               dut.register_3.reg_data, parallel_out);
    end
  endtask

  task automatic test_reset_priority;
    rst = 1'b1; enable = 1'b1; mode = 2'b10; load = 1'b1; parallel_in = 4'b1011;
    tick();
    n_cmp++;
    if (parallel_out !== 4'b1011) begin
      n_err++;
      $display("FAIL rst_prio setup: parallel_out=%b, required 1011", parallel_out);
    end
    rst = 1'b0; parallel_in = 4'b1111; serial_in = 1'b1;
    tick();
    n_cmp++;
    if (parallel_out !== 4'b0000 || serial_out !== 1'b0) begin
      n_err++;
      $display("FAIL rst_prio clear: parallel_out=%b serial_out=%b, required 0000/0", parallel_out, serial_out);
    end
    rst = 1'b1; mode = 2'b00; load = 1'b0;
    tick();
    n_cmp++;
    if (parallel_out !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_prio resume: parallel_out=%b, required 0001", parallel_out);
    end
  endtask

  task automatic test_random;
    logic [3:0] fv;
    int k;
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 15) != 0);
      enable      = ($urandom_range(0, 3) != 0);
      mode        = 2'($urandom_range(0, 3));
      load        = 1'($urandom_range(0, 1));
      serial_in   = 1'($urandom_range(0, 1));
      parallel_in = 4'($urandom);
      // Corrupt at most one replica, never in back-to-back cycles.
      k = (i % 2 == 0) ? $urandom_range(0, 3) : 0;
      fv = 4'($urandom);
      case (k)
        1: force dut.register_1.reg_data = fv;
        2: force dut.register_2.reg_data = fv;
        3: force dut.register_3.reg_data = fv;
        default: ;
      endcase
      tick();
      case (k)
        1: release dut.register_1.reg_data;
        2: release dut.register_2.reg_data;
        3: release dut.register_3.reg_data;
        default: ;
      endcase
      n_cmp++;
      if (parallel_out !== 4'(model) || serial_out !== model[3]) begin
        n_err++;
        $display("FAIL random %0d: parallel_out=%b serial_out=%b, required %b/%b",
                 i, parallel_out, serial_out, 4'(model), model[3]);
      end
      if (k == 0) begin
        n_cmp++;
        if (dut.register_1.reg_data !== 4'(model) || dut.register_2.reg_data !== 4'(model) ||
            dut.register_3.reg_data !== 4'(model)) begin
          n_err++;
          $display("FAIL random replicas %0d: r1=%b r2=%b r3=%b, required %b", i,
                   dut.register_1.reg_data, dut.register_2.reg_data, dut.register_3.reg_data, 4'(model));
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_siso();
    test_siso_fault();
    test_sipo_hold();
    test_piso();
    test_pipo_fault();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
